// File: rtl/sram_lsu.sv
// rtl/sram_lsu.sv - load/store unit sequencing byte/word accesses onto an 8-bit single-port SRAM
//
// Accepts one byte or little-endian 16-bit load/store per request handshake,
// drives the SRAM strobes for one or two byte cycles, absorbs the SRAM's
// one-cycle registered read latency, and returns a response for every access.
//
// Ports:
//   clk, Reset_n                  clock (rising edge), async active-low reset
//   req_valid/req_ready           CPU request handshake
//   req_we, req_word              store/load select, word/byte select
//   req_addr, req_wdata           byte address, store data (low byte at addr)
//   rsp_valid/rsp_ready           response handshake
//   rsp_rdata                     load data (byte loads zero-extended, 0 for stores)
//   Address, SRAMRead, SRAMWrite  SRAM address and strobes
//   Datain                        SRAM write data
//   Dataout                       SRAM read data, valid the cycle after SRAMRead
module sram_lsu #(
  parameter int ADDR_W = 8,
  parameter int BYTE_W = 8
) (
  input  logic                  clk,
  input  logic                  Reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_word,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*BYTE_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [2*BYTE_W-1:0]   rsp_rdata,
  output logic [ADDR_W-1:0]     Address,
  output logic                  SRAMRead,
  output logic                  SRAMWrite,
  output logic [BYTE_W-1:0]     Datain,
  input  logic [BYTE_W-1:0]     Dataout
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ACC0 = 3'd1,
    ACC1 = 3'd2,
    CAP  = 3'd3,
    RESP = 3'd4
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  word_q, word_d;
  logic [2*BYTE_W-1:0]   wdata_q, wdata_d;
  logic [2*BYTE_W-1:0]   rdata_q, rdata_d;

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      word_q  <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      we_q    <= we_d;
      word_q  <= word_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // SRAM pins depend only on state_q and the latched fields, never on req_*.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    we_d      = we_q;
    word_d    = word_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    SRAMRead  = 1'b0;
    SRAMWrite = 1'b0;
    Address   = addr_q;
    Datain    = wdata_q[BYTE_W-1:0];

    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          word_d  = req_word;
          wdata_d = req_wdata;
          // Cleared here so store responses return zero.
          rdata_d = '0;
          state_d = ACC0;
        end
      end

      ACC0: begin
        SRAMWrite = we_q;
        SRAMRead  = !we_q;
        if (word_q)     state_d = ACC1;
        else if (we_q)  state_d = RESP;
        else            state_d = CAP;
      end

      ACC1: begin
        // Second byte address wraps modulo 2^ADDR_W.
        Address   = addr_q + ADDR_W'(1);
        Datain    = wdata_q[2*BYTE_W-1:BYTE_W];
        SRAMWrite = we_q;
        SRAMRead  = !we_q;
        if (!we_q) begin
          // Dataout here is the low byte requested during ACC0.
          rdata_d[BYTE_W-1:0] = Dataout;
          state_d = CAP;
        end else begin
          state_d = RESP;
        end
      end

      CAP: begin
        if (word_q) rdata_d[2*BYTE_W-1:BYTE_W] = Dataout;
        else        rdata_d = {{BYTE_W{1'b0}}, Dataout};
        state_d = RESP;
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign rsp_rdata = rdata_q;

endmodule

// File: tb/tb_sram_lsu.sv
// tb/tb_sram_lsu.sv - self-checking bench for sram_lsu with behavioural SRAM and scoreboard
module tb_sram_lsu;

  logic        clk = 1'b0;
  logic        Reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_word;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [15:0] rsp_rdata;
  logic [7:0]  Address;
  logic        SRAMRead;
  logic        SRAMWrite;
  logic [7:0]  Datain;
  logic [7:0]  Dataout;

  always #5 clk = ~clk;

  sram_lsu #(.ADDR_W(8), .BYTE_W(8)) dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_word  (req_word),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .Address   (Address),
    .SRAMRead  (SRAMRead),
    .SRAMWrite (SRAMWrite),
    .Datain    (Datain),
    .Dataout   (Dataout)
  );

  // Behavioural single-port SRAM with registered read data.
  logic [7:0] mem [256] = '{default: 8'h00};
  logic [7:0] dout = 8'h00;
  always @(posedge clk) begin
    if (SRAMWrite) mem[Address] <= Datain;
    if (SRAMRead)  dout <= mem[Address];
  end
  assign Dataout = dout;

  // Reference memory updated when stimulus is issued.
  logic [7:0] ref_mem [256] = '{default: 8'h00};

  logic [15:0] exp_q[$];
  int          lat_q[$];

  int errors = 0;
  int checks = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  int         n_wr;
  int         n_rd;
  logic [7:0] addr_log[$];

  always @(negedge clk) begin
    if (Reset_n) begin
      check_eq("strobe_excl", {31'd0, SRAMRead & SRAMWrite}, 32'd0);
      if (SRAMWrite) n_wr++;
      if (SRAMRead)  n_rd++;
      if (SRAMRead || SRAMWrite) addr_log.push_back(Address);
    end
  end

  task automatic do_req(input logic we, input logic word, input logic [7:0] addr,
                        input logic [15:0] wdata, input int hold);
    int          n;
    int          lat;
    logic [7:0]  a1;
    logic [15:0] e;
    logic [15:0] held;
    a1 = addr + 8'd1;
    @(negedge clk);
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_word  = word;
    req_addr  = addr;
    req_wdata = wdata;
    rsp_ready = 1'b0;
    if (we) begin
      ref_mem[addr] = wdata[7:0];
      if (word) ref_mem[a1] = wdata[15:8];
      e = 16'h0000;
      lat = word ? 2 : 1;
    end else begin
      e = word ? {ref_mem[a1], ref_mem[addr]} : {8'h00, ref_mem[addr]};
      lat = word ? 3 : 2;
    end
    exp_q.push_back(e);
    lat_q.push_back(lat);
    n_wr = 0;
    n_rd = 0;
    addr_log.delete();
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 8'($urandom);
    req_wdata = 16'($urandom);
    req_we    = 1'($urandom);
    req_word  = 1'($urandom);
    n = 0;
    do begin
      @(posedge clk);
      n++;
      #1;
    end while (!rsp_valid && n < 10);
    check_eq("latency", n, lat_q.pop_front());
    held = rsp_rdata;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check_eq("bp_valid", {31'd0, rsp_valid}, 32'd1);
      check_eq("bp_rdata", {16'd0, rsp_rdata}, {16'd0, held});
      check_eq("bp_ready", {31'd0, req_ready}, 32'd0);
      check_eq("bp_strobe", {31'd0, SRAMRead | SRAMWrite}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    check_eq("rsp_done", {31'd0, rsp_valid}, 32'd0);
    check_eq("back_idle", {31'd0, req_ready}, 32'd1);
    check_eq("rdata", {16'd0, held}, {16'd0, exp_q.pop_front()});
    check_eq("n_write", n_wr, we ? (word ? 2 : 1) : 0);
    check_eq("n_read", n_rd, we ? 0 : (word ? 2 : 1));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_n   = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_word  = 1'b0;
    req_addr  = 8'h00;
    req_wdata = 16'h0000;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_req_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("rst_sram_read", {31'd0, SRAMRead}, 32'd0);
    check_eq("rst_sram_write", {31'd0, SRAMWrite}, 32'd0);
    check_eq("rst_address", {24'd0, Address}, 32'd0);
    check_eq("rst_datain", {24'd0, Datain}, 32'd0);
    check_eq("rst_rdata", {16'd0, rsp_rdata}, 32'd0);

    // A request presented during reset must be ignored.
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 8'h33;
    req_wdata = 16'h5A5A;
    @(posedge clk);
    #1;
    check_eq("rst_hs_ready", {31'd0, req_ready}, 32'd1);
    check_eq("rst_hs_strobe", {31'd0, SRAMWrite}, 32'd0);
    req_valid = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
    @(posedge clk);
    #1;
    check_eq("post_rst_idle", {31'd0, SRAMWrite | SRAMRead}, 32'd0);

    // Byte store then byte load.
    do_req(1'b1, 1'b0, 8'h10, 16'h00A5, 0);
    check_eq("mem_10", {24'd0, mem[8'h10]}, 32'hA5);
    do_req(1'b0, 1'b0, 8'h10, 16'h0000, 0);

    // Word store / load.
    do_req(1'b1, 1'b1, 8'h20, 16'h1234, 0);
    check_eq("mem_20", {24'd0, mem[8'h20]}, 32'h34);
    check_eq("mem_21", {24'd0, mem[8'h21]}, 32'h12);
    do_req(1'b0, 1'b1, 8'h20, 16'h0000, 0);

    // Address wrap-around.
    do_req(1'b1, 1'b1, 8'hFF, 16'hBEEF, 0);
    check_eq("wrap_addr0", {24'd0, addr_log[0]}, 32'hFF);
    check_eq("wrap_addr1", {24'd0, addr_log[1]}, 32'h00);
    do_req(1'b0, 1'b1, 8'hFF, 16'h0000, 1);

    // Response backpressure.
    do_req(1'b0, 1'b1, 8'h20, 16'h0000, 5);

    // Reset during ACC1 of a word load.
    @(negedge clk);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_word  = 1'b1;
    req_addr  = 8'h20;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    check_eq("acc1_read", {31'd0, SRAMRead}, 32'd1);
    check_eq("acc1_addr", {24'd0, Address}, 32'h21);
    Reset_n = 1'b0;
    #1;
    check_eq("mid_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check_eq("mid_rst_strobe", {31'd0, SRAMRead | SRAMWrite}, 32'd0);
    check_eq("mid_rst_ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    Reset_n = 1'b1;
    do_req(1'b0, 1'b0, 8'h10, 16'h0000, 0);

    // Random mix against the reference memory.
    for (int k = 0; k < 200; k++) begin
      logic [7:0] a;
      if ($urandom_range(0, 3) == 0) a = 8'hFE + 8'($urandom_range(0, 1));
      else                           a = 8'($urandom_range(0, 15));
      do_req(1'($urandom), 1'($urandom), a, 16'($urandom), $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
